// File: rtl/hit_burst_collector.sv
// Measures contiguous hit bursts, queues each completed length in a small FIFO
// drained by valid/ready, and keeps burst count, longest burst and overflow stats.
module hit_burst_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4,
  parameter int TOT_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     hit,
  input  logic                     clear,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [CNT_W-1:0]         out_len,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [TOT_W-1:0]         total_bursts,
  output logic [CNT_W-1:0]         max_len,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  LEN_MAX  = '1;
  localparam logic [TOT_W-1:0]  TOT_MAX  = '1;

  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic burst_end;
  logic is_full;
  logic do_pop;
  logic do_push;
  logic drop;

  always_comb begin
    burst_end = !hit && (run_len != '0);
    is_full   = (count == FULL_CNT);
    do_pop    = (count != '0) && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    do_push   = burst_end && (!is_full || do_pop);
    drop      = burst_end && is_full && !do_pop;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_len <= '0;
    end else if (hit) begin
      if (run_len != LEN_MAX) run_len <= run_len + CNT_W'(1);
    end else begin
      run_len <= '0;
    end
  end

  // NOTE: the storage array is small, so it sits on the async reset and out_len
  // never exposes stale or X contents; a large RAM would be left unreset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= run_len;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      total_bursts <= '0;
      max_len      <= '0;
      overflow     <= 1'b0;
    end else if (clear) begin
      total_bursts <= '0;
      max_len      <= '0;
      overflow     <= 1'b0;
    end else if (burst_end) begin
      if (total_bursts != TOT_MAX) total_bursts <= total_bursts + TOT_W'(1);
      if (run_len > max_len) max_len <= run_len;
      if (drop) overflow <= 1'b1;
    end
  end

  assign out_valid  = (count != '0);
  assign out_len    = out_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule
